// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble converter from a signed binary word to BCD digits plus a sign nibble
module bin2bcd_seq #(
  parameter int width = 12,
  parameter int digits = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [width-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*digits-1:0]   bcd,
  output logic [3:0]            bcd_sgn,
  output logic                  ovf
);
  localparam int nd = (width + 2) / 3 + 1;
  localparam int cw = $clog2(width);
  localparam logic [cw-1:0] last = cw'(width - 1);
  localparam logic [1:0] idle = 2'b00, shift = 2'b01, fin = 2'b10;
  logic [1:0] state;
  logic sign;
  logic [width-1:0] mag;
  logic [4*nd-1:0] scr, adj, scr_nx;
  logic [4*(nd+digits)-1:0] ext;
  logic [cw-1:0] cnt;
  logic accept, big;
  genvar i;
  for (i = 0; i < nd; i++) begin : g_adj
    assign adj[4*i+:4] = scr[4*i+:4] >= 4'd5 ? scr[4*i+:4] + 4'd3 : scr[4*i+:4];
  end
  assign scr_nx = (adj << 1) | {{(4*nd-1){1'b0}}, mag[width-1]};
  // zero-extend so the overflow test works even when digits covers the whole scratch
  assign ext = {{(4*digits){1'b0}}, scr_nx};
  assign big = |ext[4*(nd+digits)-1:4*digits];
  assign busy = state[0];
  assign done = state[1];
  assign accept = start & ~busy;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= idle;
      bcd <= '0;
      bcd_sgn <= 4'hF;
      ovf <= 1'b0;
    end else if (accept) begin
      state <= shift;
      sign <= bin[width-1];
      mag <= bin[width-1] ? -bin : bin;
      scr <= '0;
      cnt <= '0;
    end else if (busy) begin
      scr <= scr_nx;
      mag <= {mag[width-2:0], 1'b0};
      cnt <= cnt + 1'b1;
      if (cnt == last) begin
        state <= fin;
        ovf <= big;
        bcd <= big ? '1 : ext[4*digits-1:0];
        bcd_sgn <= sign ? 4'hA : 4'hF;
      end
    end else begin
      state <= idle;
    end
  end
endmodule
